// File: rtl/bk_sub_pipe.sv
// bk_sub_pipe: two-stage pipelined operand-recovery subtractor.
// Given an adder result and one operand b, it recovers a = sum - b with a
// Brent-Kung borrow-prefix network. The up-sweep is built in stage 1 and
// the down-sweep in stage 2. Results are emitted in the adder's interleaved
// operand format so they can be fed straight back into the adder.
module bk_sub_pipe #(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W:0]     in_sum,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_pair,
  output logic           out_err
);

  localparam int N2 = W / 2;
  localparam int N4 = W / 4;
  localparam int N8 = W / 8;

  // Stage valid bits
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;

  // Stage 1 data: per-bit propagate/generate, the sum carry-out, operand b
  // and the up-sweep group terms.
  logic [W-1:0]  s1_p_q, s1_p_d;
  logic [W-1:0]  s1_g_q, s1_g_d;
  logic          s1_top_q, s1_top_d;
  logic [W-1:0]  s1_b_q, s1_b_d;
  logic [N2-1:0] s1_g2_q, s1_g2_d, s1_p2_q, s1_p2_d;
  logic [N4-1:0] s1_g4_q, s1_g4_d, s1_p4_q, s1_p4_d;
  logic [N8-1:0] s1_g8_q, s1_g8_d, s1_p8_q, s1_p8_d;

  // Stage 2 (output) data
  logic [2*W-1:0] out_pair_q, out_pair_d;
  logic           out_err_q, out_err_d;

  // Combinational intermediates
  logic           s1_load, s2_load;
  logic [W-1:0]   p_in, g_in;
  logic [N2-1:0]  g2_in, p2_in;
  logic [N4-1:0]  g4_in, p4_in;
  logic [N8-1:0]  g8_in, p8_in;
  logic [W:0]     borrow;
  logic [W-1:0]   diff;
  logic           diff_top, borrow_out;
  logic           unused_group_terms;

  // Handshake: S2 advances when it is empty or being drained. S1 can take
  // new input whenever it is empty or is passing its contents on to S2.
  always_comb begin
    s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready = ~rst & (~s1_valid_q | s2_load);
    s1_load  = in_valid & in_ready;
  end

  // Up-sweep: bit-level borrow propagate/generate, then spans of 2, 4 and 8
  always_comb begin
    p_in  = in_sum[W-1:0] ^ ~in_b;
    g_in  = ~in_sum[W-1:0] & in_b;
    g2_in = '0;
    p2_in = '0;
    g4_in = '0;
    p4_in = '0;
    g8_in = '0;
    p8_in = '0;
    for (int j = 0; j < N2; j++) begin
      g2_in[j] = g_in[2*j+1] | (p_in[2*j+1] & g_in[2*j]);
      p2_in[j] = p_in[2*j+1] & p_in[2*j];
    end
    for (int j = 0; j < N4; j++) begin
      g4_in[j] = g2_in[2*j+1] | (p2_in[2*j+1] & g2_in[2*j]);
      p4_in[j] = p2_in[2*j+1] & p2_in[2*j];
    end
    for (int j = 0; j < N8; j++) begin
      g8_in[j] = g4_in[2*j+1] | (p4_in[2*j+1] & g4_in[2*j]);
      p8_in[j] = p4_in[2*j+1] & p4_in[2*j];
    end
  end

  // Down-sweep: borrow into bit k from the widest aligned group ending at k-1
  always_comb begin
    borrow    = '0;
    borrow[0] = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if ((k % 8) == 0) begin
        borrow[k] = s1_g8_q[k/8-1] | (s1_p8_q[k/8-1] & borrow[k-8]);
      end else if ((k % 4) == 0) begin
        borrow[k] = s1_g4_q[k/4-1] | (s1_p4_q[k/4-1] & borrow[k-4]);
      end else if ((k % 2) == 0) begin
        borrow[k] = s1_g2_q[k/2-1] | (s1_p2_q[k/2-1] & borrow[k-2]);
      end else begin
        borrow[k] = s1_g_q[k-1] | (s1_p_q[k-1] & borrow[k-1]);
      end
    end
    diff       = ~s1_p_q ^ borrow[W-1:0];
    diff_top   = s1_top_q ^ borrow[W];
    borrow_out = ~s1_top_q & borrow[W];
  end

  // Some group terms are never consulted by the down-sweep at this width;
  // they are kept for a uniform up-sweep and folded here as intentionally unused.
  always_comb begin
    unused_group_terms = ^{s1_g_q, s1_g2_q, s1_p2_q, s1_g4_q, s1_p4_q, s1_g8_q, s1_p8_q};
  end

  // Next-state: valid bits follow the handshake, data moves only on load
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    s1_p_d   = s1_p_q;
    s1_g_d   = s1_g_q;
    s1_top_d = s1_top_q;
    s1_b_d   = s1_b_q;
    s1_g2_d  = s1_g2_q;
    s1_p2_d  = s1_p2_q;
    s1_g4_d  = s1_g4_q;
    s1_p4_d  = s1_p4_q;
    s1_g8_d  = s1_g8_q;
    s1_p8_d  = s1_p8_q;
    if (s1_load) begin
      s1_p_d   = p_in;
      s1_g_d   = g_in;
      s1_top_d = in_sum[W];
      s1_b_d   = in_b;
      s1_g2_d  = g2_in;
      s1_p2_d  = p2_in;
      s1_g4_d  = g4_in;
      s1_p4_d  = p4_in;
      s1_g8_d  = g8_in;
      s1_p8_d  = p8_in;
    end

    out_pair_d = out_pair_q;
    out_err_d  = out_err_q;
    if (s2_load) begin
      for (int i = 0; i < W; i++) begin
        out_pair_d[2*i]   = diff[i];
        out_pair_d[2*i+1] = s1_b_q[i];
      end
      out_err_d = borrow_out | diff_top;
    end
  end

  // State registers with synchronous reset discarding everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_top_q   <= 1'b0;
      s1_b_q     <= '0;
      s1_g2_q    <= '0;
      s1_p2_q    <= '0;
      s1_g4_q    <= '0;
      s1_p4_q    <= '0;
      s1_g8_q    <= '0;
      s1_p8_q    <= '0;
      out_pair_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_p_q     <= s1_p_d;
      s1_g_q     <= s1_g_d;
      s1_top_q   <= s1_top_d;
      s1_b_q     <= s1_b_d;
      s1_g2_q    <= s1_g2_d;
      s1_p2_q    <= s1_p2_d;
      s1_g4_q    <= s1_g4_d;
      s1_p4_q    <= s1_p4_d;
      s1_g8_q    <= s1_g8_d;
      s1_p8_q    <= s1_p8_d;
      out_pair_q <= out_pair_d;
      out_err_q  <= out_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_pair  = out_pair_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_bk_sub_pipe.sv
// tb_bk_sub_pipe: scoreboard bench for the pipelined operand-recovery subtractor.
module tb_bk_sub_pipe;

  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W:0]     in_sum;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_pair;
  logic           out_err;

  typedef struct {
    logic [2*W-1:0] pair;
    logic           err;
    logic [W:0]     sum;
    logic [W-1:0]   a;
    bit             rt;
    int             acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   count = 0;
  int   or_mode = 0;
  int   bp_lo = 0;
  int   bp_hi = 0;
  bit   exact_lat = 1'b0;
  bit   cur_rt = 1'b0;
  logic [W-1:0] cur_a = '0;

  bk_sub_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pair  (out_pair),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Hard stop if something hangs beyond any reasonable run length
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide subtraction, then interleave a and b
  function automatic exp_t model(input logic [W:0] s, input logic [W-1:0] b);
    exp_t e;
    logic [W+1:0] d;
    d     = {1'b0, s} - {2'b00, b};
    e.err = d[W+1] | d[W];
    e.pair = '0;
    for (int i = 0; i < W; i++) begin
      e.pair[2*i]   = d[i];
      e.pair[2*i+1] = b[i];
    end
    e.sum = s;
    e.a   = '0;
    e.rt  = 1'b0;
    e.acc = 0;
    return e;
  endfunction

  // One clock: observe at the falling edge, advance, then drive out_ready
  task automatic tick(output bit took);
    exp_t head;
    logic [W-1:0] ra, rb;
    took = 1'b0;
    @(negedge clk);
    if (rst) begin
      checkOutput("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
    end else begin
      checkOutput("in_ready", {31'b0, in_ready}, (count < 2 || out_ready) ? 32'd1 : 32'd0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out", {31'b0, out_valid}, 32'd0);
        end else begin
          head = sb[0];
          checkOutput("pair", {8'b0, out_pair}, {8'b0, head.pair});
          checkOutput("err", {31'b0, out_err}, {31'b0, head.err});
          if (out_ready) begin
            if (exact_lat) checkOutput("latency", cyc - head.acc, 32'd2);
            else checkOutput("latency_min", {31'b0, (cyc - head.acc) >= 2}, 32'd1);
            if (head.rt) begin
              for (int i = 0; i < W; i++) begin
                ra[i] = out_pair[2*i];
                rb[i] = out_pair[2*i+1];
              end
              checkOutput("rt_a", {20'b0, ra}, {20'b0, head.a});
              checkOutput("rt_sum", {19'b0, {1'b0, ra} + {1'b0, rb}}, {19'b0, head.sum});
            end
            void'(sb.pop_front());
            count--;
          end
        end
      end
      if (in_valid && in_ready) begin
        head     = model(in_sum, in_b);
        head.rt  = cur_rt;
        head.a   = cur_a;
        head.acc = cyc;
        sb.push_back(head);
        count++;
        took = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      sb.delete();
      count = 0;
    end
    #1;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(3) != 0);
      2: out_ready = !(cyc >= bp_lo && cyc <= bp_hi);
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic applyStimulus(input logic [W:0] s, input logic [W-1:0] b, input bit rt, input logic [W-1:0] a);
    int guard = 0;
    bit took = 1'b0;
    in_valid = 1'b1;
    in_sum   = s;
    in_b     = b;
    cur_rt   = rt;
    cur_a    = a;
    do begin
      tick(took);
      guard++;
    end while (!took && guard < 200);
    if (!took) checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    bit took;
    in_valid = 1'b0;
    while (sb.size() > 0 && guard < 200) begin
      tick(took);
      guard++;
    end
    checkOutput("drain", sb.size(), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   rs;
    bit           took;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_b      = '0;
    out_ready = 1'b1;
    #1;
    tick(took);
    tick(took);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_pair", {8'b0, out_pair}, 32'd0);
    checkOutput("reset_out_err", {31'b0, out_err}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed boundary vectors, back to back with out_ready held high
    $display("[TB] directed vectors");
    exact_lat = 1'b1;
    or_mode   = 0;
    applyStimulus(13'h0FFF, 12'h001, 1'b0, '0);
    applyStimulus(13'h1000, 12'h001, 1'b0, '0);
    applyStimulus(13'h1FFE, 12'hFFF, 1'b0, '0);
    applyStimulus(13'h1FFF, 12'h000, 1'b0, '0);
    applyStimulus(13'h0003, 12'h004, 1'b0, '0);
    applyStimulus(13'h0000, 12'h000, 1'b0, '0);
    applyStimulus(13'h1FFF, 12'hFFF, 1'b0, '0);
    applyStimulus(13'h0800, 12'h800, 1'b0, '0);
    drain();

    // Backpressure: six transactions, out_ready low for cycles 3..7
    $display("[TB] backpressure");
    exact_lat = 1'b0;
    bp_lo     = cyc + 2;
    bp_hi     = cyc + 6;
    or_mode   = 2;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(13'(13'h0100 + 13'(i * 37)), 12'(i * 5), 1'b0, '0);
    end
    drain();

    // Reset with both stages full: nothing stale may come out afterwards
    $display("[TB] reset mid-stream");
    or_mode = 3;
    #0 out_ready = 1'b0;
    applyStimulus(13'h0555, 12'h111, 1'b0, '0);
    applyStimulus(13'h0AAA, 12'h222, 1'b0, '0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sum   = 13'h0777;
    in_b     = 12'h333;
    tick(took);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("post_reset_out_pair", {8'b0, out_pair}, 32'd0);
    or_mode   = 0;
    out_ready = 1'b1;
    exact_lat = 1'b1;
    applyStimulus(13'h0042, 12'h021, 1'b0, '0);
    applyStimulus(13'h1234, 12'h234, 1'b0, '0);
    drain();

    // Round trip: random a, b with sum = a + b under random backpressure
    $display("[TB] round trip");
    exact_lat = 1'b0;
    or_mode   = 1;
    for (int n = 0; n < 10000; n++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      rs = {1'b0, ra} + {1'b0, rb};
      applyStimulus(rs, rb, 1'b1, ra);
      if ($urandom_range(7) == 0) tick(took);
    end
    or_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
